// File: rtl/comb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | comb_pkg : shared types for comb_count_engine (states, stack entry, op)|
// | Rev 1.0  : initial release                                             |
// +-------------------------------------------------------------------------+
package comb_pkg;

   // Entry fields are stored at this width; the engine's N_W must not exceed it.
   localparam int C_FIELD_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      NOP          = 2'd0,
      POP          = 2'd1,
      REPLACE_PUSH = 2'd2,
      LOAD         = 2'd3
   } op_e;

   typedef struct packed {
      logic [C_FIELD_W-1:0] n;
      logic [C_FIELD_W-1:0] m;
   } entry_t;

endpackage
`default_nettype wire

// File: rtl/comb_stack.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | comb_stack : DEPTH-entry LIFO of (n,m) entries, combinational top      |
// | Rev 1.0    : initial release                                           |
// +-------------------------------------------------------------------------+
module comb_stack
   import comb_pkg::*;
#(
   parameter int DEPTH = 16
)(
   input  logic   clk,
   input  logic   rst,
   input  op_e    op_i,
   input  entry_t wr_a_i,
   input  entry_t wr_b_i,
   output entry_t top_o,
   output logic   empty_o,
   output logic   last_o
);

   localparam int PTR_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   cnt_q;
   logic [PTR_W-1:0]   cnt_d;
   logic [IDX_W-1:0]   top_idx;
   logic [IDX_W-1:0]   push_idx;

   assign top_idx  = IDX_W'(cnt_q - PTR_W'(1));
   assign push_idx = IDX_W'(cnt_q);
   assign top_o    = mem_q[top_idx];
   assign empty_o  = (cnt_q == '0);
   assign last_o   = (cnt_q == PTR_W'(1));

   always_comb begin
      cnt_d = cnt_q;
      case (op_i)
         LOAD:         cnt_d = PTR_W'(1);
         POP:          cnt_d = cnt_q - PTR_W'(1);
         REPLACE_PUSH: cnt_d = cnt_q + PTR_W'(1);
         default:      cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: an empty stack is defined by the count alone.
   always_ff @(posedge clk) begin
      case (op_i)
         LOAD: begin
            mem_q[0] <= wr_a_i;
         end
         REPLACE_PUSH: begin
            mem_q[top_idx]  <= wr_a_i;
            mem_q[push_idx] <= wr_b_i;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/comb_count_engine.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | comb_count_engine : C(n,m) by depth-first leaf counting, start/done    |
// | Option COMB_SAT_EN: saturate answer and flag ovf on counter carry-out  |
// | Rev 1.0           : initial release                                    |
// +-------------------------------------------------------------------------+
module comb_count_engine
   import comb_pkg::*;
#(
   parameter int N_W   = 4,
   parameter int DEPTH = 16,
   parameter int ANS_W = 15
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_W-1:0]   n,
   input  logic [N_W-1:0]   m,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             ovf,
   output logic [ANS_W-1:0] answer
);

   state_e             state_q, state_d;
   op_e                op;
   entry_t             top, wr_a, wr_b;
   logic               empty, last, leaf;
   logic [ANS_W-1:0]   answer_q, answer_d, inc_val;
   logic               err_q, err_d;
   logic               ovf_q, ovf_d, inc_ovf;
   logic               done_q, done_d;

   comb_stack #(
      .DEPTH (DEPTH)
   ) u_stack (
      .clk     (clk),
      .rst     (rst),
      .op_i    (op),
      .wr_a_i  (wr_a),
      .wr_b_i  (wr_b),
      .top_o   (top),
      .empty_o (empty),
      .last_o  (last)
   );

   assign leaf = (top.m == '0) || (top.m == top.n);

`ifdef COMB_SAT_EN
   logic [ANS_W:0] sum;
   assign sum     = {1'b0, answer_q} + (ANS_W+1)'(1);
   assign inc_ovf = sum[ANS_W];
   assign inc_val = sum[ANS_W] ? {ANS_W{1'b1}} : sum[ANS_W-1:0];
`else
   assign inc_ovf = 1'b0;
   assign inc_val = answer_q + ANS_W'(1);
`endif

   always_comb begin
      state_d  = state_q;
      op       = NOP;
      wr_a     = top;
      wr_b     = top;
      answer_d = answer_q;
      err_d    = err_q;
      ovf_d    = ovf_q;
      done_d   = (state_q == DONE) || (state_q == ERR);
      case (state_q)
         IDLE: begin
            if (start) begin
               answer_d = '0;
               err_d    = 1'b0;
               ovf_d    = 1'b0;
               if ((m > n) || (32'(n) >= 32'(DEPTH))) begin
                  state_d = ERR;
               end else begin
                  op      = LOAD;
                  wr_a    = '{n: C_FIELD_W'(n), m: C_FIELD_W'(m)};
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (empty) begin
               state_d = DONE;
            end else if (leaf) begin
               op       = POP;
               answer_d = inc_val;
               ovf_d    = ovf_q | inc_ovf;
               if (last) begin
                  state_d = DONE;
               end
            end else begin
               // Non-leaf nodes always have m>=1 and n>=2, so these cannot underflow.
               op   = REPLACE_PUSH;
               wr_a = '{n: top.n - C_FIELD_W'(1), m: top.m - C_FIELD_W'(1)};
               wr_b = '{n: top.n - C_FIELD_W'(1), m: top.m};
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         ERR: begin
            err_d   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         answer_q <= '0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         answer_q <= answer_d;
         err_q    <= err_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign err    = err_q;
   assign ovf    = ovf_q;
   assign answer = answer_q;

endmodule
`default_nettype wire

// File: tb/tb_comb_count_engine.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_comb_count_engine : randomized scoreboard bench, two answer widths  |
// | Rev 1.0              : initial release                                 |
// +-------------------------------------------------------------------------+
module tb_comb_count_engine;

   localparam int N_W    = 4;
   localparam int DEPTH  = 16;
   localparam int ANS_W  = 15;
   localparam int ANS_W8 = 8;

   typedef struct {
      longint ans;
      bit     err;
      bit     ovf;
      int     cyc;
      int     n;
      int     m;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_r [2];
   logic [N_W-1:0]    n_r     [2];
   logic [N_W-1:0]    m_r     [2];
   logic              busy_w  [2];
   logic              done_w  [2];
   logic              err_w   [2];
   logic              ovf_w   [2];
   logic [ANS_W-1:0]  ans0;
   logic [ANS_W8-1:0] ans1;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t q0[$];
   exp_t q1[$];

   comb_count_engine #(.N_W(N_W), .DEPTH(DEPTH), .ANS_W(ANS_W)) dut (
      .clk(clk), .rst(rst), .start(start_r[0]), .n(n_r[0]), .m(m_r[0]),
      .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .ovf(ovf_w[0]),
      .answer(ans0)
   );

   comb_count_engine #(.N_W(N_W), .DEPTH(DEPTH), .ANS_W(ANS_W8)) dut8 (
      .clk(clk), .rst(rst), .start(start_r[1]), .n(n_r[1]), .m(m_r[1]),
      .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .ovf(ovf_w[1]),
      .answer(ans1)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: closed-form binomial, then the width/saturation rule on top.
   function automatic longint binom(input int nn, input int mm);
      longint r = 1;
      for (int i = 1; i <= mm; i++) r = r * (nn - mm + i) / i;
      return r;
   endfunction

   function automatic exp_t model(input int w, input int nn, input int mm);
      exp_t   e;
      longint c;
      longint lim = longint'(1) << w;
      e.n = nn; e.m = mm; e.ovf = 1'b0;
      if (mm > nn || nn >= DEPTH) begin
         e.err = 1'b1; e.ans = 0; e.cyc = 1;
      end else begin
         c = binom(nn, mm);
         e.err = 1'b0; e.cyc = int'(2 * c);
`ifdef COMB_SAT_EN
         if (c >= lim) begin e.ans = lim - 1; e.ovf = 1'b1; end
         else e.ans = c;
`else
         e.ans = c % lim;
`endif
      end
      return e;
   endfunction

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic check_resp(input int sel, input longint a, input bit e_, input bit o_);
      exp_t e;
      int   sz;
      sz = (sel == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_done dut%0d: got done=1, expected no response", sel);
      end else begin
         if (sel == 0) e = q0.pop_front(); else e = q1.pop_front();
         chk($sformatf("answer dut%0d C(%0d,%0d)", sel, e.n, e.m), a, e.ans);
         chk($sformatf("err dut%0d C(%0d,%0d)", sel, e.n, e.m), longint'(e_), longint'(e.err));
         chk($sformatf("ovf dut%0d C(%0d,%0d)", sel, e.n, e.m), longint'(o_), longint'(e.ovf));
         chk($sformatf("done_cycle dut%0d C(%0d,%0d)", sel, e.n, e.m), longint'(cyc), longint'(e.cyc));
      end
   endtask

   always @(negedge clk) begin
      if (!rst && done_w[0]) check_resp(0, longint'(ans0), err_w[0], ovf_w[0]);
      if (!rst && done_w[1]) check_resp(1, longint'(ans1), err_w[1], ovf_w[1]);
   end

   task automatic do_reset();
      rst = 1'b1;
      q0.delete(); q1.delete();
      start_r[0] = 1'b0; start_r[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Called at a negedge with the target idle (or showing done); returns at the done negedge.
   task automatic issue(input int sel, input int nn, input int mm, input bit poke);
      exp_t e;
      int   lat;
      int   k;
      bit   bad_busy;
      bit   got;
      e   = model((sel == 0) ? ANS_W : ANS_W8, nn, mm);
      lat = e.cyc;
      start_r[sel] = 1'b1; n_r[sel] = N_W'(nn); m_r[sel] = N_W'(mm);
      @(posedge clk); #1;
      start_r[sel] = 1'b0;
      e.cyc = cyc + lat;
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
      bad_busy = 1'b0; got = 1'b0; k = 0;
      while (!got && k <= lat + 8) begin
         @(negedge clk); k++;
         if (done_w[sel]) begin
            got = 1'b1;
         end else begin
            if (!busy_w[sel]) bad_busy = 1'b1;
            if (poke && k == 3) begin
               start_r[sel] = 1'b1; n_r[sel] = N_W'(nn + 1); m_r[sel] = '0;
            end
            if (poke && k == 4) start_r[sel] = 1'b0;
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL timeout dut%0d C(%0d,%0d): got no done in %0d cycles, expected done", sel, nn, mm, k);
         do_reset();
      end else begin
         chk($sformatf("busy_while_running dut%0d C(%0d,%0d)", sel, nn, mm), longint'(bad_busy), 0);
         chk($sformatf("busy_at_done dut%0d C(%0d,%0d)", sel, nn, mm), longint'(busy_w[sel]), 0);
      end
   endtask

   initial begin
      int sel, nn, mm;
      start_r[0] = 1'b0; start_r[1] = 1'b0;
      n_r[0] = '0; n_r[1] = '0; m_r[0] = '0; m_r[1] = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("reset busy dut%0d", s), longint'(busy_w[s]), 0);
         chk($sformatf("reset done dut%0d", s), longint'(done_w[s]), 0);
         chk($sformatf("reset err dut%0d", s), longint'(err_w[s]), 0);
         chk($sformatf("reset ovf dut%0d", s), longint'(ovf_w[s]), 0);
      end
      chk("reset answer dut0", longint'(ans0), 0);
      chk("reset answer dut1", longint'(ans1), 0);
      rst = 1'b0;
      @(negedge clk);

      issue(0, 4, 2, 1'b0);
      issue(0, 5, 5, 1'b0);
      issue(0, 5, 0, 1'b0);
      issue(0, 0, 0, 1'b0);
      issue(0, 3, 4, 1'b0);
      issue(0, 15, 7, 1'b0);
      issue(1, 12, 6, 1'b0);
      issue(1, 10, 5, 1'b0);
      repeat (2) @(negedge clk);
      issue(0, 6, 3, 1'b1);
      issue(0, 4, 3, 1'b0);
      issue(0, 5, 2, 1'b0);
      repeat (2) @(negedge clk);

      // Abort a run with reset: outputs clear at once and no response appears.
      start_r[0] = 1'b1; n_r[0] = N_W'(10); m_r[0] = N_W'(5);
      @(posedge clk); #1;
      start_r[0] = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort busy", longint'(busy_w[0]), 0);
      chk("abort done", longint'(done_w[0]), 0);
      chk("abort answer", longint'(ans0), 0);
      chk("abort err", longint'(err_w[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      issue(0, 4, 1, 1'b0);

      for (int t = 0; t < 40; t++) begin
         sel = int'($urandom_range(0, 1));
         nn  = int'($urandom_range(0, 12));
         mm  = int'($urandom_range(0, 13));
         issue(sel, nn, mm, 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      if (q0.size() != 0 || q1.size() != 0) begin
         checks++; errors++;
         $display("FAIL pending_responses: got %0d outstanding, expected 0", q0.size() + q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no end of run by %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
